// File: rtl/shift_add_mult_ctrl.sv
// Sequential unsigned NxN shift-and-add multiplier on one shared 2N-bit ripple adder.
// Ports: clk, rst_n, in_valid/in_ready/a/b in, out_valid/out_ready/product out, busy. Macro: EARLY_TERM_EN.

module Sixteen_b_full_adder (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        x,
  input  logic        c_in,
  output logic [15:0] sum,
  output logic        c_out
);

  logic cy;
  logic bb;

  // x inverts the b operand (add/subtract select)
  always_comb begin
    sum = '0;
    cy  = c_in;
    bb  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bb     = b[i] ^ x;
      sum[i] = a[i] ^ bb ^ cy;
      cy     = (a[i] & bb) | (cy & (a[i] ^ bb));
    end
    c_out = cy;
  end

endmodule

module shift_add_mult_ctrl #(
  parameter int N     = 8,
  parameter int CNT_W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product,
  output logic           busy
);

  if (N != 8) begin : g_bad_n
    $error("shift_add_mult_ctrl: N must be 8");
  end
  if ((1 << CNT_W) <= N) begin : g_bad_cnt
    $error("shift_add_mult_ctrl: CNT_W too narrow");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [2*N-1:0] acc;
  logic [2*N-1:0] mcand;
  logic [2*N-1:0] addend;
  logic [2*N-1:0] sum;
  logic [N-1:0]   mplier;
  logic [CNT_W-1:0] cnt;
  logic           last_iter;
  logic           unused_c_out;

  assign addend = mplier[0] ? mcand : '0;

  // Accumulation cannot overflow 2N bits, so the carry-out stays 0
  Sixteen_b_full_adder u_add (
    .a     (acc),
    .b     (addend),
    .x     (1'b0),
    .c_in  (1'b0),
    .sum   (sum),
    .c_out (unused_c_out)
  );

`ifdef EARLY_TERM_EN
  // Stop once no multiplier bits remain after this iteration
  assign last_iter = (cnt == CNT_W'(N-1))
                  || (mplier[N-1:1] == '0);
`else
  assign last_iter = (cnt == CNT_W'(N-1));
`endif

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_iter) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            mcand  <= {{N{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          acc    <= sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (last_iter) product <= sum;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Scoreboard bench for shift_add_mult_ctrl.
// Driver pushes expected product/latency; negedge monitor pops on each new result.

module tb_shift_add_mult_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        in_ready;
  logic        out_valid;
  logic        busy;
  logic [15:0] product;

  always #5 clk = ~clk;

  shift_add_mult_ctrl #(.N(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  typedef struct {
    logic [15:0] p;
    int          e;
    int          lat;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rdy_mode = 0;
  int n_sent = 0;
  int n_got = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [7:0] bv);
`ifdef EARLY_TERM_EN
    int m;
    m = 0;
    for (int i = 0; i < 8; i++)
      if (bv[i]) m = i;
    return m + 1;
`else
    return 8;
`endif
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'b0;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    logic        pv;
    logic [15:0] held;
    exp_t        c;
    pv = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0;
      end else begin
        if (out_valid && !pv) begin
          n_got++;
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result: got %0h expected none",
                     product);
          end else begin
            c = q.pop_front();
            check("product", product, c.p);
            check("latency", cyc - c.e, c.lat);
          end
          held = product;
        end else if (out_valid) begin
          check("hold_product", product, held);
        end
        if (out_valid) check("in_ready_done", in_ready, 0);
        pv = out_valid;
      end
    end
  end

  task automatic send(input logic [7:0] av, input logic [7:0] bv,
                      input logic [15:0] pexp);
    exp_t e;
    @(negedge clk);
    a = av;
    b = bv;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (in_ready) begin
        e.p = pexp;
        e.e = cyc + 1;
        e.lat = exp_lat(bv);
        q.push_back(e);
        n_sent++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    total++;
    bad++;
    $display("FAIL send_timeout: got in_ready 0 expected 1");
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !out_valid) return;
    end
    total++;
    bad++;
    $display("FAIL drain_timeout: got pending %0d expected 0", q.size());
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    bit seen;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_product", product, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);

    send(8'd13, 8'd11, 16'd143);
    drain();

    @(negedge clk);
    a = 8'hFF;
    b = 8'hFF;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("busy_run", busy, 1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_product", product, 0);
    check("abort_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_in_ready", in_ready, 1);
    repeat (10) @(negedge clk);
    check("abort_no_result", out_valid, 0);

    send(8'hFF, 8'hFF, 16'hFE01);
    send(8'h5A, 8'h00, 16'h0000);
    send(8'h01, 8'h01, 16'h0001);
    send(8'h00, 8'hFF, 16'h0000);
    send(8'h80, 8'h80, 16'h4000);
    send(8'hFF, 8'h01, 16'h00FF);
    send(8'h01, 8'h80, 16'h0080);
    drain();

    @(negedge clk);
    rdy_mode = 1;
    @(posedge clk);
    #2;
    send(8'd3, 8'd7, 16'd21);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
    check("bp_valid_seen", 32'(seen), 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a = 8'h99;
      b = 8'h77;
      in_valid = 1'(i % 2);
      check("bp_out_valid", out_valid, 1);
      check("bp_product", product, 16'd21);
      check("bp_in_ready", in_ready, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rdy_mode = 0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("bp_release_valid", out_valid, 0);
    check("bp_release_ready", in_ready, 1);
    drain();

    rdy_mode = 2;
    for (int i = 0; i < 50; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      send(ra, rb, {8'h00, ra} * {8'h00, rb});
    end
    rdy_mode = 0;
    drain();

    check("all_results", n_got, n_sent);
    check("queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
